// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32 I/S-type fields into a 32-bit word behind a one-entry output register.
// B-type support is compiled in only when INSTR_ENCODER_BTYPE_EN is defined.
module instr_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_fmt,
   input  logic [6:0]  in_opcode,
   input  logic [2:0]  in_funct3,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [31:0] in_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_addr,
   output logic        err,
   output logic [15:0] count
);

   localparam logic [1:0] FMT_I = 2'b00;
   localparam logic [1:0] FMT_S = 2'b01;
`ifdef INSTR_ENCODER_BTYPE_EN
   localparam logic [1:0] FMT_B = 2'b10;
`endif

   logic        r_out_valid;
   logic [31:0] r_out_instr;
   logic [31:0] r_out_addr;
   logic [31:0] r_addr_cnt;
   logic [15:0] r_count;
   logic        r_err;

   logic        w_xfer;
   logic        w_fmt_ok;
   logic        w_imm_ok;
   logic        w_load;
   logic        w_reject;
   logic        w_imm12_ok;
   logic [31:0] w_word;

   // Handshake: a request transfers when in_valid && in_ready; the output word is
   // taken when out_valid && out_ready. in_ready depends combinationally only on out_ready.
   assign in_ready = !r_out_valid || out_ready;
   assign w_xfer   = in_valid && in_ready;

   assign w_imm12_ok = (in_imm[31:11] == {21{in_imm[31]}});
`ifdef INSTR_ENCODER_BTYPE_EN
   logic w_imm13_ok;
   assign w_imm13_ok = (in_imm[31:12] == {20{in_imm[31]}}) && !in_imm[0];
`endif

   always_comb begin
      w_fmt_ok = 1'b0;
      w_imm_ok = 1'b0;
      w_word   = 32'd0;
      case (in_fmt)
         FMT_I: begin
            w_fmt_ok = 1'b1;
            w_imm_ok = w_imm12_ok;
            w_word   = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
         end
         FMT_S: begin
            w_fmt_ok = 1'b1;
            w_imm_ok = w_imm12_ok;
            w_word   = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
         end
`ifdef INSTR_ENCODER_BTYPE_EN
         FMT_B: begin
            w_fmt_ok = 1'b1;
            w_imm_ok = w_imm13_ok;
            w_word   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                        in_imm[4:1], in_imm[11], in_opcode};
         end
`endif
         default: begin
            w_fmt_ok = 1'b0;
         end
      endcase
   end

   assign w_load   = w_xfer && w_fmt_ok && w_imm_ok;
   assign w_reject = w_xfer && !(w_fmt_ok && w_imm_ok);

   // A rejected request never touches the output register, address or count.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_instr <= 32'd0;
         r_out_addr  <= BASE_ADDR;
         r_addr_cnt  <= BASE_ADDR;
         r_count     <= 16'd0;
         r_err       <= 1'b0;
      end else begin
         if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_instr <= w_word;
            r_out_addr  <= r_addr_cnt;
            r_addr_cnt  <= r_addr_cnt + 32'd4;
            if (r_count != 16'hFFFF) begin
               r_count <= r_count + 16'd1;
            end
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
         if (w_reject) begin
            r_err <= 1'b1;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_instr = r_out_instr;
   assign out_addr  = r_out_addr;
   assign err       = r_err;
   assign count     = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases plus randomized traffic against
// a transaction-level reference model with an expected-word queue.
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'hFFFF_FFF0;
`ifdef INSTR_ENCODER_BTYPE_EN
  localparam bit BTYPE_EN = 1'b1;
`else
  localparam bit BTYPE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_fmt = 2'd0;
  logic [6:0]  in_opcode = 7'd0;
  logic [2:0]  in_funct3 = 3'd0;
  logic [4:0]  in_rd = 5'd0;
  logic [4:0]  in_rs1 = 5'd0;
  logic [4:0]  in_rs2 = 5'd0;
  logic [31:0] in_imm = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err;
  logic [15:0] count;

  instr_encoder #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .err(err), .count(count)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // scoreboard state: each entry is {addr, instr}
  logic [63:0] exp_q[$];
  logic [31:0] m_next_addr = BASE;
  logic [15:0] m_count = 16'd0;
  logic        m_err = 1'b0;
  logic        last_accept = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_legal(input logic [1:0] fmt, input logic [31:0] imm);
    int s;
    s = signed'(imm);
    case (fmt)
      2'd0, 2'd1: return (s >= -2048) && (s <= 2047);
      2'd2:       return BTYPE_EN && (s >= -4096) && (s <= 4094) && (s % 2 == 0);
      default:    return 1'b0;
    endcase
  endfunction

  // Field placement expressed as weighted sums of bit-field values.
  function automatic logic [31:0] ref_encode(input logic [1:0] fmt, input logic [6:0] op,
      input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [31:0] imm);
    logic [31:0] w;
    w = 32'(op) + 32'(f3) * 32'd4096 + 32'(rs1) * 32'd32768;
    case (fmt)
      2'd0: w = w + 32'(rd) * 32'd128 + (imm & 32'hFFF) * 32'd1048576;
      2'd1: w = w + (imm & 32'h1F) * 32'd128 + 32'(rs2) * 32'd1048576
                  + ((imm >> 5) & 32'h7F) * 32'd33554432;
      default: w = w + ((imm >> 11) & 32'h1) * 32'd128 + ((imm >> 1) & 32'hF) * 32'd256
                  + 32'(rs2) * 32'd1048576 + ((imm >> 5) & 32'h3F) * 32'd33554432
                  + ((imm >> 12) & 32'h1) * 32'h8000_0000;
    endcase
    return w;
  endfunction

  // One clock cycle: predict and check in_ready, update the model at the edge, check outputs.
  task automatic tick();
    logic m_ready, take, xfer;
    #1;
    m_ready = (exp_q.size() == 0) || out_ready;
    check_eq("in_ready", 32'(in_ready), 32'(m_ready));
    take = (exp_q.size() != 0) && out_ready;
    xfer = in_valid && m_ready && !rst;
    last_accept = xfer;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_next_addr = BASE;
      m_count = 16'd0;
      m_err = 1'b0;
    end else begin
      if (take) void'(exp_q.pop_front());
      if (xfer) begin
        if (ref_legal(in_fmt, in_imm)) begin
          exp_q.push_back({m_next_addr,
            ref_encode(in_fmt, in_opcode, in_funct3, in_rd, in_rs1, in_rs2, in_imm)});
          m_next_addr = m_next_addr + 32'd4;
          if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
        end else begin
          m_err = 1'b1;
        end
      end
    end
    #1;
    check_eq("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    check_eq("count", 32'(count), 32'(m_count));
    check_eq("err", 32'(err), 32'(m_err));
    if (exp_q.size() != 0) begin
      check_eq("out_instr", out_instr, exp_q[0][31:0]);
      check_eq("out_addr", out_addr, exp_q[0][63:32]);
    end
    if (rst) begin
      check_eq("rst_instr", out_instr, 32'd0);
      check_eq("rst_addr", out_addr, BASE);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input logic [1:0] fmt, input logic [6:0] op, input logic [2:0] f3,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    int n;
    n = 0;
    in_valid = 1'b1; in_fmt = fmt; in_opcode = op; in_funct3 = f3;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    do begin
      tick();
      n++;
    end while (!last_accept && n < 20);
    check_eq("send_accept", 32'(last_accept), 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    int imm_tab [12];
    logic [31:0] w1;
    logic [31:0] dec;
    logic [15:0] c0;
    imm_tab = '{-4097, -4096, -2049, -2048, -1, 0, 1, 2047, 2048, 4094, 4095, 3};

    // reset state
    do_reset();
    tick();
    check_eq("reset_valid", 32'(out_valid), 32'd0);
    check_eq("reset_count", 32'(count), 32'd0);
    check_eq("reset_err", 32'(err), 32'd0);
    check_eq("reset_addr", out_addr, BASE);

    // I-type
    out_ready = 1'b1;
    send(2'b00, 7'h13, 3'd0, 5'd5, 5'd6, 5'd0, 32'hFFFF_FFFF);
    check_eq("itype_instr", out_instr, 32'hFFF30293);
    check_eq("itype_addr", out_addr, BASE);

    // S-type with re-decode of the immediate
    send(2'b01, 7'h23, 3'd2, 5'd0, 5'd2, 5'd8, 32'd40);
    check_eq("stype_instr", out_instr, 32'h02812423);
    dec = {{20{out_instr[31]}}, out_instr[31:25], out_instr[11:7]};
    check_eq("stype_redecode", dec, 32'd40);
    check_eq("stype_addr", out_addr, BASE + 32'd4);

    // out-of-range immediate is dropped
    c0 = m_count;
    send(2'b00, 7'h13, 3'd0, 5'd1, 5'd1, 5'd0, 32'd2048);
    tick();
    check_eq("range_valid", 32'(out_valid), 32'd0);
    check_eq("range_err", 32'(err), 32'd1);
    check_eq("range_count", 32'(count), 32'(c0));
    send(2'b00, 7'h13, 3'd0, 5'd1, 5'd1, 5'd0, 32'd2047);
    check_eq("range_next_addr", out_addr, BASE + 32'd8);
    tick();

    // backpressure: three requests while the consumer stalls
    do_reset();
    out_ready = 1'b0;
    send(2'b00, 7'h13, 3'd1, 5'd3, 5'd4, 5'd0, 32'd100);
    w1 = ref_encode(2'b00, 7'h13, 3'd1, 5'd3, 5'd4, 5'd0, 32'd100);
    in_valid = 1'b1; in_fmt = 2'b01; in_opcode = 7'h23; in_imm = 32'hFFFF_FF00;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("bp_in_ready", 32'(in_ready), 32'd0);
      check_eq("bp_hold_instr", out_instr, w1);
      check_eq("bp_hold_addr", out_addr, BASE);
    end
    out_ready = 1'b1;
    send(2'b01, 7'h23, 3'd0, 5'd0, 5'd7, 5'd9, 32'hFFFF_FF00);
    check_eq("bp_addr2", out_addr, BASE + 32'd4);
    send(2'b00, 7'h03, 3'd2, 5'd10, 5'd11, 5'd0, 32'hFFFF_F800);
    check_eq("bp_addr3", out_addr, BASE + 32'd8);
    tick();
    tick();
    check_eq("bp_count", 32'(count), 32'd3);

    // reset in the middle of a stall, with err set
    send(2'b11, 7'h13, 3'd0, 5'd1, 5'd1, 5'd1, 32'd0);
    out_ready = 1'b0;
    send(2'b00, 7'h13, 3'd0, 5'd1, 5'd2, 5'd0, 32'd5);
    tick();
    check_eq("stall_valid", 32'(out_valid), 32'd1);
    do_reset();
    check_eq("rst_stall_valid", 32'(out_valid), 32'd0);
    check_eq("rst_stall_count", 32'(count), 32'd0);
    check_eq("rst_stall_err", 32'(err), 32'd0);
    out_ready = 1'b1;
    send(2'b00, 7'h13, 3'd0, 5'd1, 5'd2, 5'd0, 32'd5);
    check_eq("rst_next_addr", out_addr, BASE);
    tick();

    // B-type, or its rejection when not built in
`ifdef INSTR_ENCODER_BTYPE_EN
    send(2'b10, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8);
    check_eq("btype_instr", out_instr, 32'hFE208CE3);
    send(2'b10, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'd3);
    tick();
    check_eq("btype_odd_err", 32'(err), 32'd1);
`else
    send(2'b10, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8);
    tick();
    check_eq("btype_off_err", 32'(err), 32'd1);
    check_eq("btype_off_valid", 32'(out_valid), 32'd0);
`endif

    // randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      in_fmt    = 2'($urandom_range(0, 3));
      in_opcode = 7'($urandom);
      in_funct3 = 3'($urandom);
      in_rd     = 5'($urandom);
      in_rs1    = 5'($urandom);
      in_rs2    = 5'($urandom);
      if ($urandom_range(0, 1) == 0) in_imm = imm_tab[$urandom_range(0, 11)];
      else if ($urandom_range(0, 1) == 0) in_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      else in_imm = $urandom;
      tick();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h00000000, giving the first instruction byte address emitted after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, request holds a field set to encode.
REQ-005 SHALL have port in_ready, output, 1, encoder accepts a request this cycle.
REQ-006 SHALL have port in_fmt, input, 2, format: 00 I-type, 01 S-type, 10 B-type, 11 reserved.
REQ-007 SHALL have ports in_opcode (input, 7), in_funct3 (input, 3), in_rd (input, 5), in_rs1 (input, 5) and in_rs2 (input, 5), carrying the instruction fields.
REQ-008 SHALL have port in_imm, input, 32, signed immediate value to pack.
REQ-009 SHALL have port out_valid, output, 1, out_instr/out_addr hold an emitted word.
REQ-010 SHALL have port out_ready, input, 1, consumer takes the word this cycle.
REQ-011 SHALL have port out_instr, output, 32, encoded instruction word.
REQ-012 SHALL have port out_addr, output, 32, byte address assigned to out_instr.
REQ-013 SHALL have port err, output, 1, sticky flag: a request was rejected.
REQ-014 SHALL have port count, output, 16, number of words emitted since reset.

Function
REQ-015 SHALL accept a request on any cycle where in_valid and in_ready are both 1 (transfer).
REQ-016 SHALL drive in_ready = !out_valid || out_ready (one-entry output register, full throughput, combinational path from out_ready only).
REQ-017 SHALL register the encoded word one cycle after transfer: latency 1, out_valid = 1.
REQ-018 SHALL encode I-type as {imm[11:0], rs1, funct3, rd, opcode}.
REQ-019 SHALL encode S-type as {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-020 SHALL encode B-type as {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-021 SHALL treat an I- or S-type immediate as legal only when in_imm[31:11] are all equal, i.e. the range is -2048..2047.
REQ-022 SHALL treat a B-type immediate as legal only when in_imm[31:12] are all equal and in_imm[0] = 0, i.e. the range is -4096..4094 and even.
REQ-023 SHALL, for an accepted request that has an illegal immediate or a reserved format, drop the word, set err, and leave out_valid, out_addr and count unaffected.
REQ-024 SHALL hold out_instr and out_addr stable while out_valid = 1 and out_ready = 0.
REQ-025 SHALL assign out_addr from an internal address counter, then advance that counter by 4 for each emitted word; the counter wraps modulo 2^32.
REQ-026 SHALL increment count when a word is loaded into the output register; count saturates at 16'hFFFF.
REQ-027 SHALL, when a consumer take and a new transfer occur in the same cycle, load the new word and keep out_valid = 1 with no bubble.
REQ-028 SHALL, when a consumer take occurs and there is no legal transfer, clear out_valid on the next edge.
REQ-029 SHALL ignore in_* signals whenever in_valid = 0.

Reset
REQ-030 SHALL, while rst = 1 at a clock edge, set out_valid = 0, out_instr = 0, out_addr = BASE_ADDR, the address counter = BASE_ADDR, count = 0 and err = 0.
REQ-031 SHALL discard any held word when reset occurs mid-stall, and SHALL accept no request on the reset cycle.
REQ-032 SHALL allow err to clear only through reset.

Configuration
REQ-033 SHALL compile B-type support only when macro INSTR_ENCODER_BTYPE_EN is defined.
REQ-034 SHALL, with INSTR_ENCODER_BTYPE_EN undefined, treat in_fmt = 10 as reserved under REQ-023; REQ-020 and REQ-022 are then absent.

Verification
REQ-035 Bench SHALL cover I-type: fmt=00, opcode=7'h13, rd=5, rs1=6, funct3=0, imm=-1 -> out_instr=32'hFFF30293, out_addr=BASE_ADDR, next cycle.
REQ-036 Bench SHALL cover S-type: fmt=01, opcode=7'h23, rs1=2, rs2=8, funct3=2, imm=40 -> out_instr=32'h02812423; also check that sign-extended re-decoding returns 40.
REQ-037 Bench SHALL cover range: I-type imm=2048 -> no out_valid, err=1, count unchanged; a following legal request gets the non-advanced address.
REQ-038 Bench SHALL cover backpressure: 3 back-to-back requests with out_ready=0 for 4 cycles -> word 1 held stable, in_ready=0; after release, addresses are BASE, +4, +8 and count=3.
REQ-039 Bench SHALL cover B-type with the macro defined: fmt=10, opcode=7'h63, rs1=1, rs2=2, imm=-8 -> 32'hFE208CE3; imm=3 -> err. With the macro undefined: fmt=10 -> err.
REQ-040 Bench SHALL cover reset mid-stall with out_valid=1: rst=1 -> out_valid=0, count=0, err=0, next word at BASE_ADDR.
